// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: PC register and IF/ID register with branch/jump redirect, flush bubble and stall-deferred redirect
module fetch_redirect_ctrl #(
    parameter int unsigned PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INST = 32'h00000000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Jump,
    input  logic [PC_W-1:0]  Branch_Target,
    input  logic [PC_W-1:0]  Jump_Target,
    input  logic [31:0]      IF_Inst_org,
    output logic [PC_W-1:0]  PC,
    output logic [31:0]      ID_Inst,
    output logic [PC_W-1:0]  ID_PC4,
    output logic             ID_Valid,
    output logic             Redir_Pending,
    output logic [CNT_W-1:0] Flush_Cnt
);
    typedef enum logic {S_RUN, S_PEND} state_t;
    state_t state, state_n;
    logic [PC_W-1:0] pend_tgt, pend_tgt_n, pc_n, id_pc4_n, tgt, pc4;
    logic [31:0] id_inst_n;
    logic id_valid_n, flush;
    logic [CNT_W-1:0] cnt_inc;
    logic redirect;

    assign redirect = Branch | Jump;
    assign tgt = Jump ? Jump_Target : Branch_Target;
    assign pc4 = PC + PC_W'(4);
    assign cnt_inc = (&Flush_Cnt) ? Flush_Cnt : Flush_Cnt + CNT_W'(1);
    assign Redir_Pending = (state == S_PEND);

    // next-state and next register values; everything holds unless a case below updates it
    always_comb begin
        state_n = state;
        pend_tgt_n = pend_tgt;
        pc_n = PC;
        id_inst_n = ID_Inst;
        id_pc4_n = ID_PC4;
        id_valid_n = ID_Valid;
        flush = 1'b0;
        if (state == S_RUN) begin
            if (redirect && Stall) begin
                pend_tgt_n = tgt;
                state_n = S_PEND;
            end else if (redirect) begin
                pc_n = tgt;
                flush = 1'b1;
            end else if (!Stall) begin
                pc_n = pc4;
                id_inst_n = IF_Inst_org;
                id_pc4_n = pc4;
                id_valid_n = 1'b1;
            end
        end else if (!Stall) begin
            pc_n = pend_tgt;
            flush = 1'b1;
            state_n = S_RUN;
        end
        if (flush) begin
            id_inst_n = NOP_INST;
            id_valid_n = 1'b0;
        end
    end

    // register update with synchronous reset taking priority over all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            pend_tgt <= '0;
            PC <= RESET_PC;
            ID_Inst <= NOP_INST;
            ID_PC4 <= '0;
            ID_Valid <= 1'b0;
            Flush_Cnt <= '0;
        end else begin
            state <= state_n;
            pend_tgt <= pend_tgt_n;
            PC <= pc_n;
            ID_Inst <= id_inst_n;
            ID_PC4 <= id_pc4_n;
            ID_Valid <= id_valid_n;
            Flush_Cnt <= flush ? cnt_inc : Flush_Cnt;
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed scenario tests for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
    logic clk = 1'b0, rst = 1'b1, Stall = 1'b0, Branch = 1'b0, Jump = 1'b0;
    logic [31:0] Branch_Target = '0, Jump_Target = '0, IF_Inst_org = '0;
    logic [31:0] PC, ID_Inst, ID_PC4;
    logic ID_Valid, Redir_Pending;
    logic [7:0] Flush_Cnt;
    int checks = 0, errors = 0;

    fetch_redirect_ctrl dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Branch(Branch), .Jump(Jump),
        .Branch_Target(Branch_Target), .Jump_Target(Jump_Target), .IF_Inst_org(IF_Inst_org),
        .PC(PC), .ID_Inst(ID_Inst), .ID_PC4(ID_PC4), .ID_Valid(ID_Valid),
        .Redir_Pending(Redir_Pending), .Flush_Cnt(Flush_Cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", PC, 32'h0); end
        checks++; if (ID_Inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp %h", ID_Inst, 32'h0); end
        checks++; if (ID_PC4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp %h", ID_PC4, 32'h0); end
        checks++; if (ID_Valid !== 1'b0 || Redir_Pending !== 1'b0) begin errors++; $display("FAIL rst_flags got v=%b p=%b exp 0 0", ID_Valid, Redir_Pending); end
        checks++; if (Flush_Cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", Flush_Cnt); end
        rst = 1'b0;
        IF_Inst_org = 32'h20080005;
        step();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL t1_pc got %h exp %h", PC, 32'h4); end
        checks++; if (ID_Inst !== 32'h20080005 || ID_PC4 !== 32'h4 || ID_Valid !== 1'b1) begin errors++; $display("FAIL t1_id got %h %h %b exp 20080005 00000004 1", ID_Inst, ID_PC4, ID_Valid); end
        step();
        checks++; if (PC !== 32'h8 || ID_PC4 !== 32'h8) begin errors++; $display("FAIL t1_pc8 got %h %h exp 8 8", PC, ID_PC4); end
    endtask

    task automatic test_branch();
        Branch = 1'b1; Branch_Target = 32'h40;
        step();
        Branch = 1'b0;
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL br_pc got %h exp %h", PC, 32'h40); end
        checks++; if (ID_Inst !== 32'h0 || ID_Valid !== 1'b0 || ID_PC4 !== 32'h8) begin errors++; $display("FAIL br_bubble got %h %b %h exp 0 0 8", ID_Inst, ID_Valid, ID_PC4); end
        checks++; if (Flush_Cnt !== 8'd1) begin errors++; $display("FAIL br_cnt got %0d exp 1", Flush_Cnt); end
        step();
        checks++; if (PC !== 32'h44 || ID_PC4 !== 32'h44 || ID_Valid !== 1'b1) begin errors++; $display("FAIL br_after got %h %h %b exp 44 44 1", PC, ID_PC4, ID_Valid); end
    endtask

    task automatic test_jump_branch();
        Branch = 1'b1; Branch_Target = 32'h40; Jump = 1'b1; Jump_Target = 32'h80;
        step();
        Branch = 1'b0; Jump = 1'b0;
        checks++; if (PC !== 32'h80 || ID_Valid !== 1'b0) begin errors++; $display("FAIL jb_pc got %h v=%b exp 80 0", PC, ID_Valid); end
        checks++; if (Flush_Cnt !== 8'd2) begin errors++; $display("FAIL jb_cnt got %0d exp 2", Flush_Cnt); end
        step();
        checks++; if (PC !== 32'h84 || ID_Valid !== 1'b1) begin errors++; $display("FAIL jb_after got %h v=%b exp 84 1", PC, ID_Valid); end
    endtask

    task automatic test_stall_pending();
        Stall = 1'b1; Jump = 1'b1; Jump_Target = 32'h100;
        step();
        checks++; if (Redir_Pending !== 1'b1 || PC !== 32'h84 || ID_PC4 !== 32'h84 || ID_Valid !== 1'b1) begin errors++; $display("FAIL st1 got p=%b %h %h v=%b exp 1 84 84 1", Redir_Pending, PC, ID_PC4, ID_Valid); end
        Jump = 1'b0; Branch = 1'b1; Branch_Target = 32'h200;
        step();
        checks++; if (Redir_Pending !== 1'b1 || PC !== 32'h84) begin errors++; $display("FAIL st2 got p=%b %h exp 1 84", Redir_Pending, PC); end
        Branch = 1'b0;
        step();
        checks++; if (Redir_Pending !== 1'b1 || PC !== 32'h84 || Flush_Cnt !== 8'd2) begin errors++; $display("FAIL st3 got p=%b %h %0d exp 1 84 2", Redir_Pending, PC, Flush_Cnt); end
        Stall = 1'b0;
        step();
        checks++; if (PC !== 32'h100 || ID_Valid !== 1'b0 || ID_Inst !== 32'h0 || Redir_Pending !== 1'b0) begin errors++; $display("FAIL st_apply got %h v=%b %h p=%b exp 100 0 0 0", PC, ID_Valid, ID_Inst, Redir_Pending); end
        checks++; if (Flush_Cnt !== 8'd3) begin errors++; $display("FAIL st_cnt got %0d exp 3", Flush_Cnt); end
        step();
        checks++; if (PC !== 32'h104 || ID_Valid !== 1'b1 || Flush_Cnt !== 8'd3) begin errors++; $display("FAIL st_after got %h v=%b %0d exp 104 1 3", PC, ID_Valid, Flush_Cnt); end
    endtask

    task automatic test_reset_pending();
        Stall = 1'b1; Branch = 1'b1; Branch_Target = 32'h300;
        step();
        checks++; if (Redir_Pending !== 1'b1) begin errors++; $display("FAIL rp_enter got %b exp 1", Redir_Pending); end
        Branch = 1'b0; rst = 1'b1;
        step();
        checks++; if (PC !== 32'h0 || Redir_Pending !== 1'b0 || Flush_Cnt !== 8'd0) begin errors++; $display("FAIL rp_rst got %h p=%b %0d exp 0 0 0", PC, Redir_Pending, Flush_Cnt); end
        rst = 1'b0;
        step();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rp_hold got %h exp 0", PC); end
        Stall = 1'b0;
        step();
        checks++; if (PC !== 32'h4 || ID_Valid !== 1'b1 || Flush_Cnt !== 8'd0) begin errors++; $display("FAIL rp_nojump got %h v=%b %0d exp 4 1 0", PC, ID_Valid, Flush_Cnt); end
    endtask

    task automatic test_wrap_saturate();
        Jump = 1'b1; Jump_Target = 32'hFFFFFFF8;
        step();
        Jump = 1'b0;
        checks++; if (PC !== 32'hFFFFFFF8 || Flush_Cnt !== 8'd1) begin errors++; $display("FAIL wr_tgt got %h %0d exp fffffff8 1", PC, Flush_Cnt); end
        step();
        checks++; if (PC !== 32'hFFFFFFFC || ID_PC4 !== 32'hFFFFFFFC) begin errors++; $display("FAIL wr_fc got %h %h exp fffffffc fffffffc", PC, ID_PC4); end
        step();
        checks++; if (PC !== 32'h0 || ID_PC4 !== 32'h0) begin errors++; $display("FAIL wr_zero got %h %h exp 0 0", PC, ID_PC4); end
        Branch = 1'b1; Branch_Target = 32'h40;
        for (int i = 0; i < 253; i++) step();
        checks++; if (Flush_Cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", Flush_Cnt); end
        step();
        checks++; if (Flush_Cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", Flush_Cnt); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (Flush_Cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", Flush_Cnt); end
        checks++; if (PC !== 32'h40 || ID_Valid !== 1'b0) begin errors++; $display("FAIL sat_pc got %h v=%b exp 40 0", PC, ID_Valid); end
        Branch = 1'b0;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump_branch();
        test_stall_pending();
        test_reset_pending();
        test_wrap_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
